// File: rtl/fact_ctrl.sv
// fact_ctrl: Moore FSM sequencing an 8-bit factorial datapath with start/busy/done handshake.
// Optional FACT_CYCLE_CNT_EN adds a saturating per-run cycle count output.
module fact_ctrl #(
  parameter int WIDTH = 8,
  parameter int MAX_N = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] X_in,
  input  logic             i_lt_x,
  output logic [WIDTH-1:0] X,
  output logic             ld_i,
  output logic             ld_fi,
  output logic             ld_o,
  output logic             st,
  output logic             busy,
  output logic             done,
`ifdef FACT_CYCLE_CNT_EN
  output logic             err,
  output logic [15:0]      cycles
`else
  output logic             err
`endif
);
  localparam int IW = $clog2(MAX_N + 1);
  typedef enum logic [2:0] {IDLE, INIT, CHECK, CALC, LOAD, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] iter;
  logic accept, reject, wdog;
  assign accept = state == IDLE && start;
  assign reject = X_in > WIDTH'(MAX_N);
  assign wdog   = state == CHECK && i_lt_x && iter == IW'(MAX_N - 1);
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      X     <= '0;
      iter  <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        X    <= X_in;
        iter <= '0;
        err  <= reject;
      end else begin
        if (state == CALC) iter <= iter + 1'b1;
        if (wdog) err <= 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (reject ? DONE : INIT) : IDLE;
      INIT:    nxt = CHECK;
      CHECK:   nxt = !i_lt_x ? LOAD : (wdog ? DONE : CALC);
      CALC:    nxt = CHECK;
      LOAD:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  assign ld_i  = state == INIT || state == CALC;
  assign ld_fi = ld_i;
  assign st    = state == CALC;
  assign ld_o  = state == LOAD;
  assign done  = state == DONE;
  assign busy  = state != IDLE;
`ifdef FACT_CYCLE_CNT_EN
  // cnt equals the 1-based cycle index of the run; cycles latches it on entry to DONE
  logic [15:0] cnt;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt    <= '0;
      cycles <= '0;
    end else begin
      if (accept) cnt <= 16'd1;
      else if (busy && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      if (nxt == DONE) cycles <= state == IDLE ? 16'd1 : (cnt == 16'hFFFF ? cnt : cnt + 16'd1);
    end
  end
`endif
endmodule

// File: tb/tb_fact_ctrl.sv
// tb_fact_ctrl: directed checks of fact_ctrl driving a behavioural factorial datapath.
module tb_fact_ctrl;
  logic CLK = 1'b0, RST = 1'b0, start = 1'b0, force_cmp = 1'b0;
  logic [7:0] X_in = '0, X;
  logic i_lt_x, ld_i, ld_fi, ld_o, st, busy, done, err;
`ifdef FACT_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif
  logic [7:0] i_r = '0, fi = '0, fi_out = '0;
  int tests = 0, fails = 0;
  int done_cyc, ldo_cyc, calcs, lds, ndone, err_d, fo_d, x_bad, busy1, busy_rst, rst_calc;

  always #5 CLK = ~CLK;

  assign i_lt_x = force_cmp | (i_r < X);
  always @(posedge CLK) begin
    if (ld_i) i_r <= st ? i_r + 8'd1 : 8'd1;
    if (ld_fi) fi <= st ? fi * (i_r + 8'd1) : 8'd1;
    if (ld_o) fi_out <= fi;
  end

  fact_ctrl #(.WIDTH(8), .MAX_N(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .X_in(X_in), .i_lt_x(i_lt_x), .X(X),
    .ld_i(ld_i), .ld_fi(ld_fi), .ld_o(ld_o), .st(st), .busy(busy), .done(done),
`ifdef FACT_CYCLE_CNT_EN
    .err(err), .cycles(cycles)
`else
    .err(err)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one run with operand x; optionally inject a start (X_in=4) at cycle inj,
  // or pull reset low at cycle rk. Cycle k is the k-th cycle after the accepting edge.
  task automatic run(input logic [7:0] x, input int inj, input int rk);
    done_cyc = 0; ldo_cyc = 0; calcs = 0; lds = 0; ndone = 0;
    err_d = -1; fo_d = -1; x_bad = 0; busy1 = -1; busy_rst = -1; rst_calc = -1;
    @(negedge CLK);
    start = 1'b1; X_in = x;
    for (int k = 1; k <= 28; k++) begin
      @(negedge CLK);
      if (k == 1) begin start = 1'b0; busy1 = busy; end
      if (inj != 0 && k == inj) begin start = 1'b1; X_in = 8'd4; end
      if (inj != 0 && k == inj + 1) start = 1'b0;
      if (rk != 0 && k == rk + 1) begin busy_rst = busy; RST = 1'b1; end
      if (done) begin
        ndone++;
        if (done_cyc == 0) begin done_cyc = k; err_d = err; fo_d = fi_out; end
      end
      if (ld_o && ldo_cyc == 0) ldo_cyc = k;
      if (ld_i | ld_fi) lds++;
      if (ld_i && st) calcs++;
      if (rk == 0 && done_cyc == 0 && X !== x) x_bad = 1;
      if (rk != 0 && k == rk) begin rst_calc = ld_i && st; RST = 1'b0; end
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_X", X, 0);
    chk("rst_strobes", {ld_i, ld_fi, ld_o, st}, 0);
`ifdef FACT_CYCLE_CNT_EN
    chk("rst_cycles", cycles, 0);
`endif
    RST = 1'b1;

    run(8'd5, 0, 0);
    chk("x5_busy", busy1, 1);
    chk("x5_calcs", calcs, 4);
    chk("x5_ldo", ldo_cyc, 11);
    chk("x5_done", done_cyc, 12);
    chk("x5_err", err_d, 0);
    chk("x5_fo", fo_d, 120);
    chk("x5_ndone", ndone, 1);
    chk("x5_xhold", x_bad, 0);
`ifdef FACT_CYCLE_CNT_EN
    chk("x5_cycles", cycles, 12);
`endif

    run(8'd6, 0, 0);
    chk("x6_done", done_cyc, 1);
    chk("x6_err", err_d, 1);
    chk("x6_lds", lds, 0);
    chk("x6_ldo", ldo_cyc, 0);
    chk("x6_fo", fo_d, 120);
    chk("x6_X", X, 6);
`ifdef FACT_CYCLE_CNT_EN
    chk("x6_cycles", cycles, 1);
`endif

    run(8'd3, 0, 0);
    chk("x3_err", err_d, 0);
    chk("x3_fo", fo_d, 6);
    chk("x3_done", done_cyc, 8);
    chk("x3_calcs", calcs, 2);

    run(8'd0, 0, 0);
    chk("x0_calcs", calcs, 0);
    chk("x0_done", done_cyc, 4);
    chk("x0_fo", fo_d, 1);
    chk("x0_err", err_d, 0);

    run(8'd1, 0, 0);
    chk("x1_calcs", calcs, 0);
    chk("x1_done", done_cyc, 4);
    chk("x1_fo", fo_d, 1);
    chk("x1_err", err_d, 0);

    run(8'd3, 3, 0);
    chk("inj_fo", fo_d, 6);
    chk("inj_done", done_cyc, 8);
    chk("inj_ndone", ndone, 1);
    chk("inj_xhold", x_bad, 0);
    chk("inj_X", X, 3);

    force_cmp = 1'b1;
    run(8'd3, 0, 0);
    force_cmp = 1'b0;
    chk("wd_calcs", calcs, 4);
    chk("wd_done", done_cyc, 11);
    chk("wd_err", err_d, 1);
    chk("wd_ldo", ldo_cyc, 0);
    chk("wd_fo", fo_d, 6);

    run(8'd5, 0, 3);
    chk("rst_in_calc", rst_calc, 1);
    chk("rst_busy_after", busy_rst, 0);
    chk("rst_ndone", ndone, 0);
    chk("rst_ldo", ldo_cyc, 0);
`ifdef FACT_CYCLE_CNT_EN
    chk("rst_cycles_clr", cycles, 0);
`endif

    run(8'd2, 0, 0);
    chk("x2_done", done_cyc, 6);
    chk("x2_fo", fo_d, 2);
    chk("x2_err", err_d, 0);
    chk("x2_calcs", calcs, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Moore FSM controller that sequences the 8-bit factorial datapath: initialises the i/fi registers, iterates multiply/increment while i < X, then loads the output register.
- Provides a start/busy/done handshake to the host and holds the operand stable for the whole run.
- Rejects operands whose factorial overflows WIDTH bits.
- A watchdog catches a stuck comparator.

Parameters:
- WIDTH, 8, operand/result width
- MAX_N, 5, largest accepted operand (5! = 120 fits 8 bits); also the watchdog iteration bound; must be >= 1

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE
- X_in  input  WIDTH  operand, sampled with accepted start
- i_lt_x  input  1  datapath comparator (i < X)
- X  output  WIDTH  held operand driven to datapath comparator
- ld_i  output  1  load i register
- ld_fi  output  1  load fi register
- ld_o  output  1  load output register
- st  output  1  mux select: 0 = constant 1 (init), 1 = computed value
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  status of last run; valid from done, held until next accepted start

Behaviour:
- Reset: RST low at a rising edge -> state IDLE; X, iter, err cleared. All strobes, busy and done are 0.
- Reset mid-run aborts immediately; ld_o is never issued for the aborted run.
- Control outputs are decoded from state only (Moore); no input-to-output combinational paths.
- IDLE: start=1 latches X_in into X and clears err and iter.
  - X_in > MAX_N: set err, go to DONE (no datapath strobes).
  - Otherwise: go to INIT.
- INIT: st=0, ld_i=1, ld_fi=1 (i=1, fi=1) -> CHECK.
- CHECK: no strobes; datapath registers hold the updated values here.
  - i_lt_x=0: go to LOAD.
  - i_lt_x=1 and iter == MAX_N-1: set err (watchdog), go to DONE.
  - Otherwise: go to CALC.
- CALC: st=1, ld_i=1, ld_fi=1 (fi=fi*(i+1), i=i+1); iter+1 -> CHECK.
- LOAD: ld_o=1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored, including in DONE. start held high relaunches on the first IDLE cycle.
- Latency, counting cycles after the accepting edge (INIT = cycle 1):
  - N = X_in >= 1: done in cycle 2N+2.
  - X_in = 0: done in cycle 4 (result 1).
  - Overflow reject: done in cycle 1.
- fi_out is valid from the done cycle onward and unchanged when err=1.
- iter is a ceil(log2(MAX_N+1))-bit counter; it cannot wrap, because the watchdog bounds it.
- X is stable from acceptance until the next accepted start.

Optional Feature:
- Macro: FACT_CYCLE_CNT_EN.
- Defined:
  - Adds output cycles [15:0]: number of cycles the last run spent from the accepting edge to done, inclusive (X_in=5 -> 12).
  - Counter is internal and saturates at 16'hFFFF.
  - The output updates in the done cycle, holds otherwise, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset low 2 cycles, then start with X_in=5 -> busy rises; 4 CALC cycles; ld_o in cycle 11; done in cycle 12; err=0; datapath fi_out=120.
- X_in=0, then X_in=1 -> each run: no CALC, done in cycle 4, fi_out=1, err=0.
- X_in=6 (MAX_N=5) -> done in cycle 1, err=1, no ld_i/ld_fi/ld_o pulse, fi_out keeps 120 from the prior run. Next start with X_in=3 -> err=0, fi_out=6.
- Start pulse with X_in=4 while busy on X_in=3 run -> ignored; result 6, X stays 3, single done.
- Comparator forced to 1 with X_in=3 -> 4 CALCs, then watchdog; done in cycle 11, err=1, no ld_o.
- RST low during CALC of X_in=5 run -> next cycle IDLE, busy=0, no done or ld_o. Restart with X_in=2 -> fi_out=2 in cycle 6.
